// File: rtl/fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_arbiter
// Brief    : Round-robin burst read scheduler for a bank of synchronous FIFOs,
//            feeding a 2-entry source-tagged output buffer.
//            Optional macro FIFO_READ_ARBITER_STRICT_EN selects fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_arbiter #(
   parameter  int PORTS = 4,
   parameter  int WIDTH = 8,
   parameter  int BURST = 4,
   localparam int IDXW  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [PORTS-1:0]       src_req,
   output logic [PORTS-1:0]       src_dout_ready,
   input  logic [PORTS*WIDTH-1:0] src_dout,
   input  logic [PORTS-1:0]       src_dout_valid,
   output logic [WIDTH-1:0]       dout,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic [IDXW-1:0]        dout_source
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BURST   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic [7:0]      BURST_CNT = 8'(BURST);
   localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(PORTS - 1);

   state_t            state_q, state_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;
   logic [IDXW-1:0]   grant_q, grant_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              inflight_q, inflight_d;
   logic [IDXW-1:0]   inflight_src_q, inflight_src_d;
   logic [1:0]        occ_q, occ_d;
   logic [WIDTH-1:0]  hd_data_q, hd_data_d, tl_data_q, tl_data_d;
   logic [IDXW-1:0]   hd_src_q, hd_src_d, tl_src_q, tl_src_d;

   logic              pop, push, miss, credit, strobe, any_req;
   logic [2:0]        committed;
   logic [1:0]        occ_mid;
   logic [WIDTH-1:0]  cap_data;
   logic [IDXW-1:0]   rr_pick;

   assign dout_valid  = (occ_q != 2'd0);
   assign dout        = hd_data_q;
   assign dout_source = hd_src_q;
   assign pop         = dout_valid & dout_ready;
   assign push        = inflight_q & src_dout_valid[inflight_src_q];
   assign miss        = inflight_q & ~src_dout_valid[inflight_src_q];
   assign any_req     = |src_req;

   // Words already owed to the buffer: a new strobe is legal only if its
   // word will still find a free slot when it lands next cycle.
   assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign credit    = (committed < 3'd2);

   always_comb begin
      cap_data = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (inflight_src_q == IDXW'(i)) begin
            cap_data = src_dout[i*WIDTH +: WIDTH];
         end
      end
   end

`ifdef FIFO_READ_ARBITER_STRICT_EN
   always_comb begin
      rr_pick = '0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         if (src_req[i]) begin
            rr_pick = IDXW'(i);
         end
      end
   end
`else
   logic [IDXW:0] rr_sum;
   logic          rr_found;

   always_comb begin
      rr_pick  = '0;
      rr_found = 1'b0;
      rr_sum   = '0;
      for (int i = 0; i < PORTS; i++) begin
         rr_sum = {1'b0, ptr_q} + (IDXW+1)'(i);
         if (rr_sum >= (IDXW+1)'(PORTS)) begin
            rr_sum = rr_sum - (IDXW+1)'(PORTS);
         end
         if (!rr_found && src_req[rr_sum[IDXW-1:0]]) begin
            rr_found = 1'b1;
            rr_pick  = rr_sum[IDXW-1:0];
         end
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      strobe  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d = rr_pick;
               cnt_d   = '0;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            // A miss means the hint was stale: give the grant up at once.
            if (!src_req[grant_q] || (miss && (inflight_src_q == grant_q))) begin
               state_d = ST_RELEASE;
            end else if (credit) begin
               strobe = 1'b1;
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == BURST_CNT) begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
`ifdef FIFO_READ_ARBITER_STRICT_EN
            ptr_d = ptr_q;
`else
            ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDXW'(1);
`endif
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      src_dout_ready = '0;
      if (strobe) begin
         src_dout_ready[grant_q] = 1'b1;
      end
   end

   assign inflight_d     = strobe;
   assign inflight_src_d = strobe ? grant_q : inflight_src_q;

   always_comb begin
      hd_data_d = hd_data_q;
      hd_src_d  = hd_src_q;
      tl_data_d = tl_data_q;
      tl_src_d  = tl_src_q;
      occ_mid   = occ_q - {1'b0, pop};
      if (pop) begin
         hd_data_d = tl_data_q;
         hd_src_d  = tl_src_q;
      end
      if (push) begin
         if (occ_mid == 2'd0) begin
            hd_data_d = cap_data;
            hd_src_d  = inflight_src_q;
         end else begin
            tl_data_d = cap_data;
            tl_src_d  = inflight_src_q;
         end
      end
      occ_d = occ_mid + {1'b0, push};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         ptr_q          <= '0;
         grant_q        <= '0;
         cnt_q          <= '0;
         inflight_q     <= 1'b0;
         inflight_src_q <= '0;
         occ_q          <= '0;
         hd_data_q      <= '0;
         hd_src_q       <= '0;
         tl_data_q      <= '0;
         tl_src_q       <= '0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         grant_q        <= grant_d;
         cnt_q          <= cnt_d;
         inflight_q     <= inflight_d;
         inflight_src_q <= inflight_src_d;
         occ_q          <= occ_d;
         hd_data_q      <= hd_data_d;
         hd_src_q       <= hd_src_d;
         tl_data_q      <= tl_data_d;
         tl_src_q       <= tl_src_d;
      end
   end

endmodule
`default_nettype wire
